// File: rtl/bist_controller_pkg.sv
// Shared BIST definitions: FSM state encoding, datapath width and the seed/golden constants
// that the controller and the LFSR/MISR datapath must agree on.
package bist_pkg;

    localparam int BIST_WIDTH     = 8;
    localparam int BIST_CNT_WIDTH = 16;

    localparam logic [BIST_WIDTH-1:0] BIST_DEFAULT_SEED = 8'h01;
    localparam logic [BIST_WIDTH-1:0] BIST_GOLDEN_SIG   = 8'h5C;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        RUN     = 3'd2,
        FLUSH   = 3'd3,
        COMPARE = 3'd4,
        DONE    = 3'd5
    } bist_state_t;

    // Busy covers everything from seeding to the signature compare.
    function automatic logic isBusyState(input bist_state_t state);
        return (state == INIT) || (state == RUN) || (state == FLUSH) || (state == COMPARE);
    endfunction

endpackage

// File: rtl/bist_controller_if.sv
// Control/status bundle between the test requester, the BIST controller and the LFSR/MISR datapath.
interface bist_controller_if #(
    parameter int WIDTH = bist_pkg::BIST_WIDTH
);

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] misr_sig;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             misr_clr;
    logic             misr_en;
    logic             test_mode;
    logic [15:0]      pattern_cnt;
    logic             busy;
    logic             done;
    logic             pass;

    modport master (
        output start,
        output abort,
        output misr_sig,
        input  lfsr_load,
        input  lfsr_en,
        input  misr_clr,
        input  misr_en,
        input  test_mode,
        input  pattern_cnt,
        input  busy,
        input  done,
        input  pass
    );

    modport slave (
        input  start,
        input  abort,
        input  misr_sig,
        output lfsr_load,
        output lfsr_en,
        output misr_clr,
        output misr_en,
        output test_mode,
        output pattern_cnt,
        output busy,
        output done,
        output pass
    );

endinterface

// File: rtl/bist_controller_counter.sv
// Pattern index counter: synchronous clear (wins over enable), increment on enable,
// and a flag that is high while the count sits on the terminal value.
module bist_pattern_counter #(
    parameter int CNT_WIDTH = 16,
    parameter int TERMINAL  = 254
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_enable,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_terminal
);

    localparam logic [CNT_WIDTH-1:0] TERMINAL_VALUE = CNT_WIDTH'(TERMINAL);
    localparam logic [CNT_WIDTH-1:0] ONE            = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == TERMINAL_VALUE);

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the LFSR, clears the MISR, runs NUM_PATTERNS patterns, flushes the
// last response, then compares the signature with GOLDEN_SIG and reports done/pass.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               WIDTH        = BIST_WIDTH,
    parameter int               NUM_PATTERNS = 255,
    parameter logic [WIDTH-1:0] GOLDEN_SIG   = BIST_GOLDEN_SIG
) (
    input logic              clk,
    input logic              rst,
    bist_controller_if.slave bus
);

    bist_state_t r_state;
    bist_state_t w_nextState;

    logic        r_pass;
    logic        w_lfsrLoad;
    logic        w_lfsrEn;
    logic        w_misrClr;
    logic        w_misrEn;
    logic        w_testMode;
    logic        w_busy;
    logic        w_done;
    logic        w_cntClear;
    logic        w_cntEnable;
    logic        w_terminal;
    logic [15:0] w_patternCnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Abort outranks every transition, including a start seen in the same cycle.
    always_comb begin
        w_nextState = r_state;
        w_lfsrLoad  = 1'b0;
        w_lfsrEn    = 1'b0;
        w_misrClr   = 1'b0;
        w_misrEn    = 1'b0;
        w_testMode  = isBusyState(r_state);
        w_busy      = isBusyState(r_state);
        w_done      = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = INIT;
                end
            end
            INIT: begin
                w_lfsrLoad  = 1'b1;
                w_misrClr   = 1'b1;
                w_nextState = RUN;
            end
            RUN: begin
                w_lfsrEn = 1'b1;
                w_misrEn = 1'b1;
                if (w_terminal) begin
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                w_misrEn    = 1'b1;
                w_nextState = COMPARE;
            end
            COMPARE: begin
                w_nextState = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_nextState = INIT;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (bus.abort) begin
            w_nextState = IDLE;
        end
    end

    // Clearing on entry to INIT/IDLE keeps the count at zero for the whole INIT cycle,
    // and the terminal gate makes the count hold on its last index after RUN.
    assign w_cntClear  = (w_nextState == IDLE) || (w_nextState == INIT);
    assign w_cntEnable = (r_state == RUN) && !w_terminal;

    bist_pattern_counter #(
        .CNT_WIDTH (BIST_CNT_WIDTH),
        .TERMINAL  (NUM_PATTERNS - 1)
    ) u_patternCounter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cntClear),
        .i_enable   (w_cntEnable),
        .o_count    (w_patternCnt),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pass <= 1'b0;
        end else if ((w_nextState == IDLE) || (w_nextState == INIT)) begin
            r_pass <= 1'b0;
        end else if (r_state == COMPARE) begin
            r_pass <= (bus.misr_sig == GOLDEN_SIG);
        end
    end

    assign bus.lfsr_load   = w_lfsrLoad;
    assign bus.lfsr_en     = w_lfsrEn;
    assign bus.misr_clr    = w_misrClr;
    assign bus.misr_en     = w_misrEn;
    assign bus.test_mode   = w_testMode;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.pass        = r_pass;
    assign bus.pattern_cnt = w_patternCnt;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: a 4-pattern instance covers reset, pass/fail, abort and
// reset-mid-run; a 1-pattern instance covers the minimum run length and restart from DONE.
module tb_bist_controller;

    // Output vector order: lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass
    localparam logic [7:0] EXP_IDLE    = 8'b0000_0000;
    localparam logic [7:0] EXP_INIT    = 8'b1010_1100;
    localparam logic [7:0] EXP_RUN     = 8'b0101_1100;
    localparam logic [7:0] EXP_FLUSH   = 8'b0001_1100;
    localparam logic [7:0] EXP_COMPARE = 8'b0000_1100;
    localparam logic [7:0] EXP_PASS    = 8'b0000_0011;
    localparam logic [7:0] EXP_FAIL    = 8'b0000_0010;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bist_controller_if #(.WIDTH(8)) bus4 ();
    bist_controller_if #(.WIDTH(8)) bus1 ();

    bist_controller #(
        .WIDTH        (8),
        .NUM_PATTERNS (4),
        .GOLDEN_SIG   (8'h5C)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    bist_controller #(
        .WIDTH        (8),
        .NUM_PATTERNS (1),
        .GOLDEN_SIG   (8'h5C)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [7:0] vec4;
    logic [7:0] vec1;

    assign vec4 = {bus4.lfsr_load, bus4.lfsr_en, bus4.misr_clr, bus4.misr_en,
                   bus4.test_mode, bus4.busy, bus4.done, bus4.pass};
    assign vec1 = {bus1.lfsr_load, bus1.lfsr_en, bus1.misr_clr, bus1.misr_en,
                   bus1.test_mode, bus1.busy, bus1.done, bus1.pass};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one unit's inputs, then advances one rising edge and settles 1 time unit past it.
    task automatic applyStimulus(input int unitSel, input logic startIn, input logic abortIn,
                                 input logic [7:0] sigIn);
        if (unitSel == 4) begin
            bus4.start    = startIn;
            bus4.abort    = abortIn;
            bus4.misr_sig = sigIn;
        end else begin
            bus1.start    = startIn;
            bus1.abort    = abortIn;
            bus1.misr_sig = sigIn;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int unitSel, input string tag, input logic [7:0] expVec,
                               input logic [15:0] expCnt);
        logic [7:0]  obsVec;
        logic [15:0] obsCnt;
        obsVec = (unitSel == 4) ? vec4 : vec1;
        obsCnt = (unitSel == 4) ? bus4.pattern_cnt : bus1.pattern_cnt;
        checks++;
        assert (obsVec === expVec) else begin
            errors++;
            $error("[TB] FAIL %s outputs observed=%b expected=%b", tag, obsVec, expVec);
        end
        checks++;
        assert (obsCnt === expCnt) else begin
            errors++;
            $error("[TB] FAIL %s pattern_cnt observed=%0d expected=%0d", tag, obsCnt, expCnt);
        end
    endtask

    // Full 4-pattern run from IDLE through DONE, with the signature presented at COMPARE.
    task automatic runToDone(input string name, input logic [7:0] sig, input logic [7:0] expDone);
        applyStimulus(4, 1'b1, 1'b0, sig);
        checkOutput(4, {name, "_init"}, EXP_INIT, 16'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4, 1'b0, 1'b0, sig);
            checkOutput(4, $sformatf("%s_run%0d", name, i), EXP_RUN, 16'(i));
        end
        applyStimulus(4, 1'b0, 1'b0, sig);
        checkOutput(4, {name, "_flush"}, EXP_FLUSH, 16'd3);
        applyStimulus(4, 1'b0, 1'b0, sig);
        checkOutput(4, {name, "_compare"}, EXP_COMPARE, 16'd3);
        applyStimulus(4, 1'b0, 1'b0, sig);
        checkOutput(4, {name, "_done"}, expDone, 16'd3);
        applyStimulus(4, 1'b0, 1'b0, ~sig);
        checkOutput(4, {name, "_hold"}, expDone, 16'd3);
        applyStimulus(4, 1'b0, 1'b1, sig);
        checkOutput(4, {name, "_abort"}, EXP_IDLE, 16'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus4.start    = 1'b1;
        bus4.abort    = 1'b0;
        bus4.misr_sig = 8'h00;
        bus1.start    = 1'b1;
        bus1.abort    = 1'b0;
        bus1.misr_sig = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput(4, "reset4", EXP_IDLE, 16'd0);
        checkOutput(1, "reset1", EXP_IDLE, 16'd0);

        bus1.start = 1'b0;
        rst        = 1'b1;
        applyStimulus(4, 1'b0, 1'b0, 8'h5C);
        checkOutput(4, "idle", EXP_IDLE, 16'd0);

        runToDone("pass", 8'h5C, EXP_PASS);
        runToDone("fail", 8'h5D, EXP_FAIL);

        applyStimulus(4, 1'b1, 1'b0, 8'h5C);
        checkOutput(4, "ab_init", EXP_INIT, 16'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4, 1'b0, 1'b0, 8'h5C);
            checkOutput(4, $sformatf("ab_run%0d", i), EXP_RUN, 16'(i));
        end
        applyStimulus(4, 1'b1, 1'b1, 8'h5C);
        checkOutput(4, "ab_idle", EXP_IDLE, 16'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4, 1'b0, 1'b0, 8'h5C);
            checkOutput(4, $sformatf("ab_quiet%0d", i), EXP_IDLE, 16'd0);
        end

        applyStimulus(4, 1'b1, 1'b0, 8'h5C);
        checkOutput(4, "rs_init", EXP_INIT, 16'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4, 1'b0, 1'b0, 8'h5C);
        end
        applyStimulus(4, 1'b0, 1'b0, 8'h5C);
        checkOutput(4, "rs_flush", EXP_FLUSH, 16'd3);
        rst = 1'b0;
        applyStimulus(4, 1'b0, 1'b0, 8'h5C);
        checkOutput(4, "rs_reset", EXP_IDLE, 16'd0);
        rst = 1'b1;
        applyStimulus(4, 1'b0, 1'b0, 8'h5C);
        checkOutput(4, "rs_idle", EXP_IDLE, 16'd0);
        runToDone("clean", 8'h5C, EXP_PASS);

        applyStimulus(1, 1'b1, 1'b0, 8'h5C);
        checkOutput(1, "n1_init", EXP_INIT, 16'd0);
        applyStimulus(1, 1'b1, 1'b0, 8'h5C);
        checkOutput(1, "n1_run", EXP_RUN, 16'd0);
        applyStimulus(1, 1'b1, 1'b0, 8'h5C);
        checkOutput(1, "n1_flush", EXP_FLUSH, 16'd0);
        applyStimulus(1, 1'b1, 1'b0, 8'h5C);
        checkOutput(1, "n1_compare", EXP_COMPARE, 16'd0);
        applyStimulus(1, 1'b1, 1'b0, 8'h5C);
        checkOutput(1, "n1_done", EXP_PASS, 16'd0);
        applyStimulus(1, 1'b1, 1'b0, 8'h5D);
        checkOutput(1, "n1_restart", EXP_INIT, 16'd0);
        applyStimulus(1, 1'b0, 1'b0, 8'h5D);
        checkOutput(1, "n1b_run", EXP_RUN, 16'd0);
        applyStimulus(1, 1'b0, 1'b0, 8'h5D);
        checkOutput(1, "n1b_flush", EXP_FLUSH, 16'd0);
        applyStimulus(1, 1'b0, 1'b0, 8'h5D);
        checkOutput(1, "n1b_compare", EXP_COMPARE, 16'd0);
        applyStimulus(1, 1'b0, 1'b0, 8'h5D);
        checkOutput(1, "n1b_done", EXP_FAIL, 16'd0);
        applyStimulus(1, 1'b0, 1'b1, 8'h5D);
        checkOutput(1, "n1b_abort", EXP_IDLE, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencer for the 8-bit BIST datapath. It puts the pattern LFSR and the `final_misr` signature register through one complete self-test: clear and seed, run N patterns, flush the last response, compare against the golden signature, then report. It sits between the system test request and the BIST datapath and owns every enable and clear those registers see.

## Interface
Parameters:
- `WIDTH`, 8: width of the pattern and signature buses.
- `NUM_PATTERNS`, 255: patterns applied per run. Legal range 1..2^16-1.
- `GOLDEN_SIG`, 8'h5C: expected MISR signature after a fault-free run.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: run request, level-sampled.
- `abort`  in  1: cancel the current run.
- `misr_sig`  in  WIDTH: current MISR output (`qout`).
- `lfsr_load`  out  1: load the LFSR seed.
- `lfsr_en`  out  1: advance the LFSR.
- `misr_clr`  out  1: clear the MISR to 0.
- `misr_en`  out  1: MISR compacts its `z` input this cycle.
- `test_mode`  out  1: CUT input mux selects the LFSR pattern.
- `pattern_cnt`  out  16: index of the pattern being applied.
- `busy`  out  1: a run is in progress.
- `done`  out  1: run complete, `pass` is valid.
- `pass`  out  1: signature matched `GOLDEN_SIG`.

## Operation
- Moore FSM. All outputs are registered or decoded from the state register only.
- States:
  - IDLE: all outputs 0. If `start`=1, go to INIT.
  - INIT, 1 cycle: `lfsr_load`=1, `misr_clr`=1, `busy`=1, `test_mode`=1. `pass` and `done` are cleared, `pattern_cnt`=0. Go to RUN.
  - RUN, NUM_PATTERNS cycles: `lfsr_en`=1, `misr_en`=1, `busy`=1, `test_mode`=1. `pattern_cnt` increments each cycle. Leave for FLUSH when `pattern_cnt`=NUM_PATTERNS-1.
  - FLUSH, 1 cycle: `misr_en`=1, `lfsr_en`=0, `busy`=1, `test_mode`=1. This absorbs the one-cycle CUT-to-MISR latency. Go to COMPARE.
  - COMPARE, 1 cycle: `busy`=1, `test_mode`=1. Registers `pass <= (misr_sig == GOLDEN_SIG)`. Go to DONE.
  - DONE: `done`=1, `pass` held, `busy`=0, `test_mode`=0. If `start`=1, go to INIT (restart). Otherwise stay in DONE until `abort`=1, then go to IDLE.
- `start` is ignored in INIT, RUN, FLUSH and COMPARE. It is not queued.
- `abort`=1 in any state other than IDLE moves to IDLE on the next edge. All outputs then return to 0, including `pass`.
- `abort` has priority over `start` in the same cycle.
- `pattern_cnt` is 16-bit unsigned and never wraps within a run. It holds its last value in FLUSH, COMPARE and DONE. It is cleared in INIT and IDLE.
- NUM_PATTERNS=1: RUN lasts exactly 1 cycle.

## Timing
- Reset: when `rst`=0 at an edge, the state goes to IDLE and every output goes to 0. This overrides `start` and `abort` and applies mid-run.
- Edge numbering: call the edge that samples `start`=1 in IDLE edge 0.
  - `busy` rises after edge 0.
  - RUN occupies the cycles after edges 1..N.
  - `done` rises after edge N+3 and `busy` falls on the same edge.
- Latency from the start request to `done` is N+3 clock cycles.
- `pass` is stable from the first DONE cycle onward.
- Restart from DONE: `done` falls on the edge that enters INIT.
- `misr_sig` is sampled only in COMPARE.

## Structure
- Shared package `bist_pkg` holds:
  - the state enum `bist_state_t` (IDLE, INIT, RUN, FLUSH, COMPARE, DONE);
  - `BIST_WIDTH`=8;
  - the default seed and golden-signature constants used by both the controller and the datapath.
- One natural sub-module, `bist_pattern_counter`: a 16-bit counter with clear, enable and a terminal-count flag at NUM_PATTERNS-1. The FSM is otherwise flat.

## Test plan
- Reset: hold `rst`=0 with `start`=1 for 3 cycles -> all outputs 0, state IDLE.
- Pass run: NUM_PATTERNS=4, pulse `start`, `misr_sig`=8'h5C at COMPARE -> INIT 1 cycle, `lfsr_en` high for 4 cycles, `misr_en` high for 5, `done`=1 and `pass`=1 after edge 7. `pattern_cnt` steps 0,1,2,3.
- Fail run: same as the pass run but `misr_sig`=8'h5D -> `done`=1, `pass`=0, after edge 7.
- Abort mid-run: assert `abort` when `pattern_cnt`=2 -> IDLE next edge, all outputs 0, `done` never rises.
- Reset mid-run: drive `rst`=0 during FLUSH -> all outputs 0 next edge. A later `start` runs a full, clean sequence.
- Restart and minimum length: NUM_PATTERNS=1, hold `start` high through DONE -> `done` high 1 cycle, then INIT clears `pass`. The second run ends with `done` after edge 4 of its own count.
